ma_host_requester: RTL and testbench

//   Initiator side of the MA dictionary-compressor command interface.

---
 rtl/ma_pkg.sv | 28 ++
 rtl/ma_host_requester.sv | 149 ++++++++++++++
 tb/tb_ma_host_requester.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ma_pkg.sv
// Shared types and default widths for the MA dictionary compressor and its host requester.
package ma_pkg;

    localparam int unsigned DATA_W_DEF = 80;
    localparam int unsigned IDX_W_DEF  = 8;

    typedef enum logic [1:0] {
        MA_NOP    = 2'd0,
        MA_COMP   = 2'd1,
        MA_DECOMP = 2'd2,
        MA_ERR    = 2'd3
    } ma_cmd_e;

    typedef enum logic [1:0] {
        RSP_NONE   = 2'd0,
        RSP_COMP   = 2'd1,
        RSP_DECOMP = 2'd2,
        RSP_ERR    = 2'd3
    } ma_rsp_e;

    typedef enum logic [1:0] {
        ST_COMP_OK   = 2'b00,
        ST_DECOMP_OK = 2'b01,
        ST_MA_ERR    = 2'b10,
        ST_TIMEOUT   = 2'b11
    } host_status_e;

endpackage

// File: rtl/ma_host_requester.sv
// Initiator for the MA compressor: issues one command per request, waits (with timeout)
// for MA's response and hands the result back on a valid/ready port.
module ma_host_requester
    import ma_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned IDX_W   = IDX_W_DEF,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_data,
    input  logic [IDX_W-1:0]  req_index,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [IDX_W-1:0]  rsp_index,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        ma_command,
    output logic [DATA_W-1:0] ma_data_in,
    output logic [IDX_W-1:0]  ma_compressed_in,
    input  logic [IDX_W-1:0]  ma_compressed_out,
    input  logic [DATA_W-1:0] ma_decompressed_out,
    input  logic [1:0]        ma_response,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic                op_q, op_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    index_q, index_d;
    ma_cmd_e             cmd_q, cmd_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    host_status_e        status_q, status_d;
    logic [IDX_W-1:0]    rsp_index_q, rsp_index_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [7:0]          err_q, err_d;
    ma_rsp_e             rsp_code;
    ma_rsp_e             rsp_expected;
    logic                to_err;

    assign rsp_code     = ma_rsp_e'(ma_response);
    assign rsp_expected = op_q ? RSP_DECOMP : RSP_COMP;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        index_d     = index_q;
        cmd_d       = MA_NOP;
        timer_d     = timer_q;
        status_d    = status_q;
        rsp_index_d = rsp_index_q;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;
        to_err      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Any ma_response arriving here is stale and dropped.
                if (req_valid) begin
                    op_d    = req_op;
                    data_d  = req_data;
                    index_d = req_index;
                    cmd_d   = req_op ? MA_DECOMP : MA_COMP;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                timer_d = timer_q + 1'b1;
                if (rsp_code == rsp_expected) begin
                    status_d    = op_q ? ST_DECOMP_OK : ST_COMP_OK;
                    rsp_index_d = op_q ? '0 : ma_compressed_out;
                    rsp_data_d  = op_q ? ma_decompressed_out : '0;
                    state_d     = StResp;
                end else if (rsp_code != RSP_NONE) begin
                    status_d = ST_MA_ERR;
                    to_err   = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    status_d = ST_TIMEOUT;
                    to_err   = 1'b1;
                end
                if (to_err) begin
                    rsp_index_d = '0;
                    rsp_data_d  = '0;
                    state_d     = StResp;
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= 1'b0;
            data_q      <= '0;
            index_q     <= '0;
            cmd_q       <= MA_NOP;
            timer_q     <= '0;
            status_q    <= ST_COMP_OK;
            rsp_index_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            index_q     <= index_d;
            cmd_q       <= cmd_d;
            timer_q     <= timer_d;
            status_q    <= status_d;
            rsp_index_q <= rsp_index_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    assign req_ready        = (state_q == StIdle);
    assign busy             = (state_q != StIdle);
    assign rsp_valid        = (state_q == StResp);
    assign rsp_status       = status_q;
    assign rsp_index        = rsp_index_q;
    assign rsp_data         = rsp_data_q;
    assign ma_command       = cmd_q;
    assign ma_data_in       = data_q;
    assign ma_compressed_in = index_q;
    assign err_count        = err_q;

endmodule

// File: tb/tb_ma_host_requester.sv
// Bench for ma_host_requester against a behavioural MA dictionary model; a monitor checks
// every response handshake against a scoreboard queue filled by the stimulus.
module tb_ma_host_requester;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [79:0] req_data = '0;
    logic [7:0]  req_index = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_status;
    logic [7:0]  rsp_index;
    logic [79:0] rsp_data;
    logic [1:0]  ma_command;
    logic [79:0] ma_data_in;
    logic [7:0]  ma_compressed_in;
    logic [7:0]  ma_compressed_out;
    logic [79:0] ma_decompressed_out;
    logic [1:0]  ma_response;
    logic        busy;
    logic [7:0]  err_count;

    always #2 clk = ~clk;

    ma_host_requester #(.DATA_W(80), .IDX_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_op              (req_op),
        .req_data            (req_data),
        .req_index           (req_index),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_status          (rsp_status),
        .rsp_index           (rsp_index),
        .rsp_data            (rsp_data),
        .ma_command          (ma_command),
        .ma_data_in          (ma_data_in),
        .ma_compressed_in    (ma_compressed_in),
        .ma_compressed_out   (ma_compressed_out),
        .ma_decompressed_out (ma_decompressed_out),
        .ma_response         (ma_response),
        .busy                (busy),
        .err_count           (err_count)
    );

    // Behavioural MA: registered one-cycle response pulse, dictionary filled in order.
    logic [79:0] dict [256];
    int          ma_cnt;
    logic        ma_mute = 1'b0;

    function automatic int find(input logic [79:0] d);
        for (int i = 0; i < ma_cnt; i++) begin
            if (dict[i] == d) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma_cnt              <= 0;
            ma_response         <= 2'd0;
            ma_compressed_out   <= '0;
            ma_decompressed_out <= '0;
        end else begin
            ma_response <= 2'd0;
            if (!ma_mute && ma_command == 2'd1) begin
                if (find(ma_data_in) >= 0) begin
                    ma_compressed_out <= 8'(find(ma_data_in));
                    ma_response       <= 2'd1;
                end else if (ma_cnt < 256) begin
                    dict[ma_cnt]      <= ma_data_in;
                    ma_compressed_out <= 8'(ma_cnt);
                    ma_cnt            <= ma_cnt + 1;
                    ma_response       <= 2'd1;
                end else begin
                    ma_response <= 2'd3;
                end
            end else if (!ma_mute && ma_command == 2'd2) begin
                if (int'(ma_compressed_in) < ma_cnt) begin
                    ma_decompressed_out <= dict[ma_compressed_in];
                    ma_response         <= 2'd2;
                end else begin
                    ma_response <= 2'd3;
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rsp   = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [1:0]  st;
        logic [7:0]  ix;
        logic [79:0] d;
        int          ecyc;
    } exp_t;

    exp_t sb[$];

    // Monitor: compares every response handshake with the oldest expectation.
    initial begin
        logic rv_prev;
        int   rise_cyc;
        exp_t e;
        rv_prev  = 1'b0;
        rise_cyc = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid && !rv_prev) rise_cyc = cyc;
            if (rsp_valid && rsp_ready && !reset) begin
                n_rsp++;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 80'd1, 80'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_status", 80'(rsp_status), 80'(e.st));
                    check("rsp_index", 80'(rsp_index), 80'(e.ix));
                    check("rsp_data", rsp_data, e.d);
                    if (e.ecyc > 0) check("rsp_latency", 80'(rise_cyc), 80'(e.ecyc));
                end
            end
            rv_prev = rsp_valid;
        end
    end

    task automatic push(input logic [1:0] st, input logic [7:0] ix, input logic [79:0] d,
                        input int ecyc);
        exp_t e;
        e.st = st; e.ix = ix; e.d = d; e.ecyc = ecyc;
        sb.push_back(e);
    endtask

    task automatic send(input logic op, input logic [79:0] d, input logic [7:0] ix,
                        output int acc);
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_op = op; req_data = d; req_index = ix;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (acc < 0) check("accept_timeout", 80'd0, 80'd1);
    endtask

    task automatic wait_hs(input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("rsp_timeout", 80'd0, 80'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int last;
        int n;
        int rsp_base;
        do_reset();
        @(negedge clk);
        check("reset_req_ready", 80'(req_ready), 80'd1);
        check("reset_busy", 80'(busy), 80'd0);
        check("reset_rsp_valid", 80'(rsp_valid), 80'd0);
        check("reset_ma_command", 80'(ma_command), 80'd0);
        check("reset_err_count", 80'(err_count), 80'd0);

        // 1) compress 7 -> index 0, one-cycle command pulse
        send(1'b0, 80'h7, 8'h0, acc);
        push(2'b00, 8'd0, 80'd0, acc + 3);
        @(negedge clk);
        check("issue_cmd_comp", 80'(ma_command), 80'd1);
        @(negedge clk);
        check("cmd_back_to_nop", 80'(ma_command), 80'd0);
        check("ma_data_in_held", ma_data_in, 80'h7);
        wait_hs(40);

        // 2) decompress index 0 -> 7
        send(1'b1, 80'h0, 8'd0, acc);
        push(2'b01, 8'd0, 80'h7, acc + 3);
        @(negedge clk);
        check("issue_cmd_decomp", 80'(ma_command), 80'd2);
        wait_hs(40);

        // 3) dictionary hit, then decompress an unwritten index
        send(1'b0, 80'h7, 8'h0, acc);
        push(2'b00, 8'd0, 80'd0, acc + 3);
        wait_hs(40);
        send(1'b1, 80'h0, 8'd1, acc);
        push(2'b10, 8'd0, 80'd0, acc + 3);
        wait_hs(40);
        check("err_count_after_ma_err", 80'(err_count), 80'd1);

        // 4) silent MA -> timeout; hold off the consumer and check outputs stay put
        ma_mute = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        send(1'b0, 80'h55, 8'h0, acc);
        push(2'b11, 8'd0, 80'd0, acc + 2 + TIMEOUT);
        for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_valid", 80'(rsp_valid), 80'd1);
            check("hold_status", 80'(rsp_status), 80'd3);
            check("hold_index", 80'(rsp_index), 80'd0);
            check("hold_data", rsp_data, 80'd0);
            check("hold_req_ready", 80'(req_ready), 80'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_hs(10);
        check("err_count_after_timeout", 80'(err_count), 80'd2);

        // 5) reset while waiting on MA, then a normal compress
        send(1'b0, 80'h9, 8'h0, acc);
        @(negedge clk);
        @(negedge clk);
        check("busy_in_wait", 80'(busy), 80'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 80'(busy), 80'd0);
        check("abort_ma_command", 80'(ma_command), 80'd0);
        check("abort_rsp_valid", 80'(rsp_valid), 80'd0);
        check("abort_err_count", 80'(err_count), 80'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ma_mute = 1'b0;
        send(1'b0, 80'h7, 8'h0, acc);
        push(2'b00, 8'd0, 80'd0, acc + 3);
        wait_hs(40);

        // 6) back-to-back stream of 20 compressions into a fresh dictionary
        do_reset();
        rsp_base = n_rsp;
        @(posedge clk);
        #1;
        req_op = 1'b0; req_data = 80'h1000; req_valid = 1'b1;
        n = 0;
        last = 0;
        for (int c = 0; c < 200 && n < 20; c++) begin
            @(negedge clk);
            if (req_ready) begin
                push(2'b00, 8'(n), 80'd0, cyc + 3);
                if (n > 0) check("stream_gap", 80'(cyc - last), 80'd4);
                last = cyc;
                n++;
                @(posedge clk);
                #1;
                req_data = 80'h1000 + 80'(n);
                if (n == 20) req_valid = 1'b0;
            end
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("sb_drained", 80'(sb.size()), 80'd0);
        check("stream_rsp_count", 80'(n_rsp - rsp_base), 80'd20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
